// File: rtl/scan_pkg.sv
// Shared types and constants for the HUB-75 row/frame scan scheduler.
package scan_pkg;

  typedef enum logic [2:0] {
    kInit,
    kIdle,
    kFill,
    kWaitIdle,
    kStart,
    kRun
  } scan_state_e;

  localparam int unsigned kDriverBusyCycles = 88;
  localparam int unsigned kRowWidth         = 5;
  localparam int unsigned kFrameCountWidth  = 10;

  function automatic logic [kRowWidth-1:0] next_row(input logic [kRowWidth-1:0] row,
                                                    input int unsigned row_count);
    return (row == kRowWidth'(row_count - 1)) ? '0 : row + 1'b1;
  endfunction

endpackage

// File: rtl/cascade_counter.sv
// Wrapping counter with carry chaining; carry_out fires on the increment that wraps to zero.
module cascade_counter #(
  parameter int unsigned Width    = 5,
  parameter int unsigned MaxValue = 31
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_carry_in,
  output logic [Width-1:0] o_value,
  output logic [Width-1:0] o_next,
  output logic             o_carry_out
);

  logic [Width-1:0] r_value;
  logic             w_at_max;

  assign w_at_max    = (r_value == Width'(MaxValue));
  assign o_next      = w_at_max ? '0 : r_value + 1'b1;
  assign o_carry_out = i_carry_in && w_at_max;
  assign o_value     = r_value;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_value <= '0;
    end else if (i_clear) begin
      r_value <= '0;
    end else if (i_carry_in) begin
      r_value <= o_next;
    end
  end

endmodule

// File: rtl/scan_fill_requester.sv
// Line-buffer fill handshake: holds fill_req/fill_row until ack and tracks a filled-ahead row.
module scan_fill_requester
  import scan_pkg::*;
(
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_req_set,
  input  logic [kRowWidth-1:0] i_req_row,
  input  logic                 i_clear_ready,
  input  logic                 i_fill_ack,
  output logic                 o_fill_req,
  output logic [kRowWidth-1:0] o_fill_row,
  output logic                 o_ack_accept,
  output logic                 o_next_ready
);

  logic                 r_fill_req;
  logic [kRowWidth-1:0] r_fill_row;
  logic                 r_next_ready;
  logic                 w_ack_accept;

  assign w_ack_accept = r_fill_req && i_fill_ack;

  // A new request wins over the ack it coincides with; the ack is consumed by the same start.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_fill_req   <= 1'b0;
      r_fill_row   <= '0;
      r_next_ready <= 1'b0;
    end else begin
      if (i_req_set) begin
        r_fill_req <= 1'b1;
        r_fill_row <= i_req_row;
      end else if (w_ack_accept) begin
        r_fill_req <= 1'b0;
      end
      if (i_clear_ready) begin
        r_next_ready <= 1'b0;
      end else if (w_ack_accept) begin
        r_next_ready <= 1'b1;
      end
    end
  end

  assign o_fill_req   = r_fill_req;
  assign o_fill_row   = r_fill_row;
  assign o_ack_accept = w_ack_accept;
  assign o_next_ready = r_next_ready;

endmodule

// File: rtl/scan_scheduler.sv
// Row/frame sequencer for the HUB-75 path: fills each row's buffer half, then starts the Driver.
// Define SCAN_SCHEDULER_PREFETCH_EN to fill row+1 while row is being driven.
module scan_scheduler
  import scan_pkg::*;
#(
  parameter int unsigned ROW_COUNT       = 32,
  parameter int unsigned FRAME_COUNT_MAX = 'h3ff
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        i_enable,
  output logic                        o_fill_req,
  output logic [kRowWidth-1:0]        o_fill_row,
  input  logic                        i_fill_ack,
  output logic [kRowWidth-1:0]        o_drive_y,
  output logic [kFrameCountWidth-1:0] o_drive_frame_count,
  output logic                        o_drive_start,
  input  logic                        i_drive_is_idle,
  output logic                        o_frame_done
);

  scan_state_e                 r_state, w_state_d;
  logic [kRowWidth-1:0]        r_drive_y;
  logic [kFrameCountWidth-1:0] r_drive_frame_count;
  logic                        r_drive_start;
  logic                        r_frame_done;

  logic [kRowWidth-1:0]        w_row, w_row_next, w_start_row, w_req_row;
  logic [kFrameCountWidth-1:0] w_frame, w_frame_next, w_start_frame;
  logic                        w_row_clear, w_row_inc, w_row_carry;
  logic                        w_req_set, w_clear_ready, w_start;
  logic                        w_fill_req, w_ack_accept, w_next_ready;

  cascade_counter #(
    .Width    (kRowWidth),
    .MaxValue (ROW_COUNT - 1)
  ) u_row_counter (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_clear     (w_row_clear),
    .i_carry_in  (w_row_inc),
    .o_value     (w_row),
    .o_next      (w_row_next),
    .o_carry_out (w_row_carry)
  );

  cascade_counter #(
    .Width    (kFrameCountWidth),
    .MaxValue (FRAME_COUNT_MAX)
  ) u_frame_counter (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_clear     (1'b0),
    .i_carry_in  (w_row_carry),
    .o_value     (w_frame),
    .o_next      (w_frame_next),
    .o_carry_out ()
  );

  scan_fill_requester u_fill_requester (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_req_set     (w_req_set),
    .i_req_row     (w_req_row),
    .i_clear_ready (w_clear_ready),
    .i_fill_ack    (i_fill_ack),
    .o_fill_req    (w_fill_req),
    .o_fill_row    (o_fill_row),
    .o_ack_accept  (w_ack_accept),
    .o_next_ready  (w_next_ready)
  );

  always_comb begin
    w_state_d     = r_state;
    w_row_clear   = 1'b0;
    w_row_inc     = 1'b0;
    w_req_set     = 1'b0;
    w_req_row     = '0;
    w_clear_ready = 1'b0;
    unique case (r_state)
      kInit: w_state_d = kIdle;
      kIdle: begin
        // An outstanding fill from before the stop must finish before restarting at row 0.
        if (i_enable && !w_fill_req) begin
          w_state_d     = kFill;
          w_row_clear   = 1'b1;
          w_req_set     = 1'b1;
          w_clear_ready = 1'b1;
        end
      end
      kFill: begin
        if (w_ack_accept || w_next_ready) w_state_d = i_enable ? kWaitIdle : kIdle;
      end
      kWaitIdle: begin
        if (i_drive_is_idle) w_state_d = kStart;
      end
      kStart: w_state_d = kRun;
      kRun: begin
        if (i_drive_is_idle) begin
          w_row_inc = 1'b1;
          if (!i_enable) begin
            w_state_d = kIdle;
`ifdef SCAN_SCHEDULER_PREFETCH_EN
          end else if (w_next_ready || w_ack_accept) begin
            w_state_d = kStart;
          end else begin
            w_state_d = kFill;
          end
`else
          end else begin
            w_state_d = kFill;
            w_req_set = 1'b1;
            w_req_row = w_row_next;
          end
`endif
        end
      end
      default: w_state_d = kInit;
    endcase

    w_start       = (w_state_d == kStart);
    w_start_row   = (r_state == kRun) ? w_row_next : w_row;
    w_start_frame = (r_state == kRun && w_row_carry) ? w_frame_next : w_frame;
    if (w_start) w_clear_ready = 1'b1;
`ifdef SCAN_SCHEDULER_PREFETCH_EN
    // Row+1 has the opposite parity, so it lands in the half the Driver is not reading.
    if (w_start) begin
      w_req_set = 1'b1;
      w_req_row = next_row(w_start_row, ROW_COUNT);
    end
`endif
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state             <= kInit;
      r_drive_y           <= '0;
      r_drive_frame_count <= '0;
      r_drive_start       <= 1'b0;
      r_frame_done        <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_drive_start <= w_start;
      r_frame_done  <= w_row_carry;
      if (w_start) begin
        r_drive_y           <= w_start_row;
        r_drive_frame_count <= w_start_frame;
      end
    end
  end

  assign o_fill_req          = w_fill_req;
  assign o_drive_y           = r_drive_y;
  assign o_drive_frame_count = r_drive_frame_count;
  assign o_drive_start       = r_drive_start;
  assign o_frame_done        = r_frame_done;

endmodule

// File: tb/tb_scan_scheduler.sv
// Directed bench for scan_scheduler with loader/Driver models and a start scoreboard.
module tb_scan_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       fill_req;
  logic [4:0] fill_row;
  logic       fill_ack = 1'b0;
  logic [4:0] drive_y;
  logic [9:0] drive_frame_count;
  logic       drive_start;
  logic       drive_is_idle;
  logic       frame_done;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int busy = 0;
  int ld_lat = 10;
  int ld_cnt = 0;
  int rises = 0;
  int viol = 0;
  logic fill_req_prev = 1'b0;

  typedef struct {int y; int fc;} exp_t;
  exp_t exp_q[$];
  int   starts[$];
  int   rise_snap[$];
  int   fd[$];

  scan_scheduler #(
    .ROW_COUNT       (32),
    .FRAME_COUNT_MAX (2)
  ) u_dut (
    .i_clock             (clk),
    .i_reset             (rst),
    .i_enable            (enable),
    .o_fill_req          (fill_req),
    .o_fill_row          (fill_row),
    .i_fill_ack          (fill_ack),
    .o_drive_y           (drive_y),
    .o_drive_frame_count (drive_frame_count),
    .o_drive_start       (drive_start),
    .i_drive_is_idle     (drive_is_idle),
    .o_frame_done        (frame_done)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Driver: idle low from the cycle after start until 89 cycles after it.
  assign drive_is_idle = (busy == 0);
  always @(posedge clk) begin
    if (drive_start) busy <= 88;
    else if (busy > 0) busy <= busy - 1;
  end

  // Loader: ack arrives ld_lat cycles after fill_req rises.
  always @(posedge clk) begin
    if (fill_req && !fill_ack) begin
      if (ld_cnt >= ld_lat - 1) begin
        fill_ack <= 1'b1;
        ld_cnt   <= 0;
      end else begin
        ld_cnt <= ld_cnt + 1;
      end
    end else begin
      fill_ack <= 1'b0;
      ld_cnt   <= 0;
    end
  end

  task automatic check(input string tag, input int got, input int want);
    n_checks++;
    assert (got === want) else begin
      n_errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  function automatic int exp_period(input int lat);
`ifdef SCAN_SCHEDULER_PREFETCH_EN
    return (lat <= 89) ? 90 : lat + 2;
`else
    return 90 + lat + 2;
`endif
  endfunction

  function automatic int start_at(input int i);
    return (i < starts.size()) ? starts[i] : -100000;
  endfunction

  function automatic int rise_at(input int i);
    return (i < rise_snap.size()) ? rise_snap[i] : -100000;
  endfunction

  function automatic int outs();
    logic [22:0] v;
    v = {fill_req, fill_row, drive_y, drive_frame_count, drive_start, frame_done};
    return int'(v);
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      fill_req_prev <= fill_req;
      if (fill_req && !fill_req_prev) rises <= rises + 1;
      if (fill_req && busy != 0 && fill_row[0] == drive_y[0]) viol <= viol + 1;
      if (frame_done) fd.push_back(cyc);
      if (drive_start) begin
        starts.push_back(cyc);
        rise_snap.push_back(rises);
        check("sb_unexpected_start", (exp_q.size() > 0) ? 1 : 0, 1);
        if (exp_q.size() > 0) begin
          check("sb_frame_row", int'({drive_frame_count, drive_y}),
                exp_q[0].fc * 32 + exp_q[0].y);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic wait_starts(input int n, input int budget, input string tag);
    int waited = 0;
    while (starts.size() < n && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    check(tag, (starts.size() >= n) ? 1 : 0, 1);
  endtask

  initial begin
    int e_cyc;
    int r0;
    rst    = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", outs(), 0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("idle_no_fill_req", rises, 0);
    check("idle_no_start", starts.size(), 0);

    // Phase 1: rows 0..37, stop during row 5 of frame 1.
    for (int k = 0; k < 38; k++) exp_q.push_back('{y: k % 32, fc: k / 32});
    e_cyc  = cyc;
    enable = 1'b1;
    wait_starts(4, 600, "wait_first_rows");
    check("first_start_latency", start_at(0) - e_cyc, 13);
    for (int i = 1; i < 4; i++) check("row_period_lat10", start_at(i) - start_at(i - 1),
                                      exp_period(10));
    wait_starts(38, 6000, "wait_row37");
    check("frame_done_cycle", (fd.size() > 0) ? fd[0] : -1, start_at(31) + 90);
    repeat (40) @(negedge clk);
    enable = 1'b0;
    repeat (300) @(negedge clk);
    check("stopped_after_row", starts.size(), 38);
    check("fill_idle_after_stop", int'(fill_req), 0);
    check("frame_done_count", fd.size(), 1);
    check("queue_drained_1", exp_q.size(), 0);

    // Phase 2: restart at row 0 with frame count kept, run through the frame wrap.
    for (int k = 0; k < 72; k++)
      exp_q.push_back('{y: k % 32, fc: (k < 32) ? 1 : ((k < 64) ? 2 : 0)});
    enable = 1'b1;
    @(negedge clk);
    check("restart_fill_row0", int'({fill_req, fill_row}), 32);
    wait_starts(103, 9000, "wait_wrap_row");
    ld_lat = 120;
    wait_starts(105, 1000, "wait_lat120_rows");
    check("row_period_lat120_a", start_at(103) - start_at(102), exp_period(120));
    check("row_period_lat120_b", start_at(104) - start_at(103), exp_period(120));
    check("one_fill_per_row_a", rise_at(103) - rise_at(102), 1);
    check("one_fill_per_row_b", rise_at(104) - rise_at(103), 1);
    ld_lat = 10;
    wait_starts(110, 1200, "wait_row7");
    check("half_conflicts", viol, 0);

    // Asynchronous reset while row 7 is being driven.
    repeat (20) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("reset_mid_run", outs(), 0);
    check("queue_drained_2", exp_q.size(), 0);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    r0  = rises;
    repeat (10) @(negedge clk);
    check("no_fill_after_reset", rises - r0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
